// File: rtl/serial_mismatch_counter_pkg.sv
// serial_mismatch_counter_pkg: shared FSM state encoding and default frame length
package serial_mismatch_counter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;
  localparam int FRAME_LEN_DEF = 8;
endpackage

// File: rtl/serial_mismatch_counter_xor_nor_cell.sv
// xor_nor_cell: 1-bit difference y = a ^ b built from five NOR gates
module xor_nor_cell (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  logic n1, n2, n3, n4;
  assign n1  = ~(a_i | b_i);
  assign n2  = ~(a_i | n1);
  assign n3  = ~(b_i | n1);
  assign n4  = ~(n2 | n3);
  assign y_o = ~(n4 | n4);
endmodule

// File: rtl/serial_mismatch_counter.sv
// serial_mismatch_counter: per-frame Hamming distance, difference parity and equality of two serial streams.
// Defining MISMATCH_ABORT_EN ends a frame at its first mismatching beat.
module serial_mismatch_counter
  import serial_mismatch_counter_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             parity,
  output logic [CNT_W-1:0] mismatch_cnt
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic             par_q, par_d, eq_q, eq_d, diff, last;
  xor_nor_cell u_diff (.a_i(in_a), .b_i(in_b), .y_o(diff));
`ifdef MISMATCH_ABORT_EN
  assign last = (idx_q == CNT_W'(FRAME_LEN - 1)) || diff;
`else
  assign last = idx_q == CNT_W'(FRAME_LEN - 1);
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    eq_d    = eq_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        cnt_d   = '0;
        par_d   = 1'b0;
        idx_d   = '0;
      end
      RUN: if (in_valid) begin
        cnt_d = cnt_q + CNT_W'(diff);
        par_d = par_q ^ diff;
        idx_d = idx_q + CNT_W'(1);
        if (last) begin
          state_d = DONE;
          eq_d    = cnt_d == '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      eq_q    <= eq_d;
      idx_q   <= idx_d;
    end
  end
  assign in_ready     = state_q == RUN;
  assign busy         = state_q == RUN;
  assign done         = state_q == DONE;
  assign equal        = eq_q;
  assign parity       = par_q;
  assign mismatch_cnt = cnt_q;
endmodule

// File: tb/tb_serial_mismatch_counter.sv
// tb_serial_mismatch_counter: table-driven and randomized frames against a countones-based reference model
module tb_serial_mismatch_counter;
  localparam int FL = 8;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0;
  logic in_ready, busy, done, equal, parity;
  logic [CW-1:0] mismatch_cnt;
  int checks = 0, errors = 0, prev_eq = 0;
  serial_mismatch_counter #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_ready(in_ready), .busy(busy), .done(done), .equal(equal), .parity(parity),
    .mismatch_cnt(mismatch_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [FL-1:0] a, b;
    bit stall, mstart;
    int cnt, par, eq;
  } vec_t;
  vec_t tbl[5];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Reference: Hamming distance by popcount; abort mode stops at the first differing beat (MSB first)
  function automatic void model(input logic [FL-1:0] a, input logic [FL-1:0] b,
                                output int cnt, output int beats);
    logic [FL-1:0] d;
    d = a ^ b;
    beats = FL;
    cnt = $countones(d);
`ifdef MISMATCH_ABORT_EN
    for (int k = 0; k < FL; k++)
      if (d[FL-1-k]) begin
        beats = k + 1;
        cnt = 1;
        break;
      end
`endif
  endfunction
  task automatic run_frame(input string nm, input logic [FL-1:0] a, input logic [FL-1:0] b,
                           input bit stall, input bit mstart, input int ecnt, input int epar,
                           input int eeq);
    int beats, mcnt, i, dones, cyc;
    bit acc;
    model(a, b, mcnt, beats);
    start = 1'b1;
    step;
    start = 1'b0;
    chk({nm, " run after start"}, {in_ready, busy, done}, 3'b110);
    chk({nm, " equal held at start"}, equal, prev_eq);
    i = 0;
    dones = 0;
    cyc = 0;
    while (dones == 0 && cyc < 100) begin
      in_valid = stall ? (cyc % 3 == 0) : 1'b1;
      in_a = (i < FL) ? a[FL-1-i] : 1'b0;
      in_b = (i < FL) ? b[FL-1-i] : 1'b0;
      start = mstart && (cyc == 2);
      acc = in_valid && in_ready;
      step;
      if (acc) i++;
      if (done) begin
        dones++;
        chk({nm, " done right after last beat"}, {acc, i == beats}, 2'b11);
      end
      cyc++;
    end
    start = 1'b0;
    chk({nm, " done seen"}, dones, 1);
    chk({nm, " beats consumed"}, i, beats);
    chk({nm, " mismatch_cnt"}, mismatch_cnt, ecnt);
    chk({nm, " parity"}, parity, epar);
    chk({nm, " equal"}, equal, eeq);
    chk({nm, " ready/busy in done"}, {in_ready, busy}, 2'b00);
    in_valid = 1'b1;
    in_a = 1'b1;
    in_b = 1'b0;
    step;
    step;
    in_valid = 1'b0;
    chk({nm, " idle after done"}, {in_ready, busy, done}, 3'b000);
    chk({nm, " results held"}, {mismatch_cnt, parity, equal}, {ecnt[CW-1:0], epar[0], eeq[0]});
    prev_eq = eeq;
  endtask
  initial begin
    tbl[0] = '{8'b10110010, 8'b10110010, 1'b0, 1'b0, 0, 0, 1};
`ifdef MISMATCH_ABORT_EN
    tbl[1] = '{8'b11110000, 8'b00000000, 1'b0, 1'b0, 1, 1, 0};
    tbl[2] = '{8'b11100000, 8'b00000000, 1'b0, 1'b0, 1, 1, 0};
    tbl[3] = '{8'b00110000, 8'b00000000, 1'b1, 1'b1, 1, 1, 0};
`else
    tbl[1] = '{8'b11110000, 8'b00000000, 1'b0, 1'b0, 4, 0, 0};
    tbl[2] = '{8'b11100000, 8'b00000000, 1'b0, 1'b0, 3, 1, 0};
    tbl[3] = '{8'b11110000, 8'b00000000, 1'b1, 1'b1, 4, 0, 0};
`endif
    tbl[4] = '{8'b00100000, 8'b00000000, 1'b0, 1'b0, 1, 1, 0};
    for (int k = 0; k < 4; k++) begin
      start = 1'($urandom);
      in_valid = 1'($urandom);
      in_a = 1'($urandom);
      in_b = 1'($urandom);
      step;
      chk("reset outputs", {in_ready, busy, done, equal, parity, mismatch_cnt}, '0);
    end
    start = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    step;
    chk("idle after reset", {in_ready, busy, done}, 3'b000);
    for (int k = 0; k < 5; k++)
      run_frame($sformatf("vec%0d", k), tbl[k].a, tbl[k].b, tbl[k].stall, tbl[k].mstart,
                tbl[k].cnt, tbl[k].par, tbl[k].eq);
    start = 1'b1;
    step;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 1'b0;
    in_b = 1'b0;
    for (int k = 0; k < 5; k++) step;
    #2 rst_n = 1'b0;
    #1;
    chk("mid-frame reset clears", {in_ready, busy, done, equal, parity, mismatch_cnt}, '0);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("no done after reset", done, 0);
    end
    rst_n = 1'b1;
    prev_eq = 0;
    step;
    run_frame("equal after reset", 8'hA5, 8'hA5, 1'b0, 1'b0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      logic [FL-1:0] a, b;
      int c, bt;
      a = FL'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : FL'($urandom);
      model(a, b, c, bt);
      run_frame($sformatf("rand%0d", k), a, b, 1'($urandom), 1'($urandom), c, c % 2, c == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
